// File: rtl/dram_cmd_timeline_gen.sv
// Per-request DRAM command timeline generator: turns read requests into time-stamped
// PRE/ACT/RD commands while tracking open rows and per-bank / per-bank-group timing history.
module dram_cmd_timeline_gen #(
  parameter int BG_WIDTH     = 2,
  parameter int BANK_WIDTH   = 2,
  parameter int ROW_WIDTH    = 16,
  parameter int COL_WIDTH    = 10,
  parameter int REQ_ID_WIDTH = 8,
  parameter int CYCLE_WIDTH  = 16,
  parameter int T_RCD        = 14,
  parameter int T_RP         = 14,
  parameter int T_RAS        = 32,
  parameter int T_RTP        = 8,
  parameter int T_RRD_S      = 4,
  parameter int T_RRD_L      = 6,
  parameter int T_CCD_S      = 4,
  parameter int T_CCD_L      = 6,
  parameter int T_FAW        = 24,
  parameter int AUTO_CLOSE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [BG_WIDTH-1:0]     req_bg,
  input  logic [BANK_WIDTH-1:0]   req_bank,
  input  logic [ROW_WIDTH-1:0]    req_row,
  input  logic [COL_WIDTH-1:0]    req_col,
  input  logic [REQ_ID_WIDTH-1:0] req_id,
  input  logic                    req_last,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [CYCLE_WIDTH-1:0]  cmd_cycle,
  output logic [2:0]              cmd_type,
  output logic [BG_WIDTH-1:0]     cmd_bg,
  output logic [BANK_WIDTH-1:0]   cmd_bank,
  output logic [ROW_WIDTH-1:0]    cmd_row,
  output logic [COL_WIDTH-1:0]    cmd_col,
  output logic [REQ_ID_WIDTH-1:0] cmd_req_id,
  output logic                    busy,
  output logic                    overflow,
  output logic [2:0]              dbg_state_o
);

  localparam int NB_W = BG_WIDTH + BANK_WIDTH;
  localparam int NB   = 1 << NB_W;
  localparam int NBG  = 1 << BG_WIDTH;
  localparam int CW   = CYCLE_WIDTH;
  localparam int CW1  = CYCLE_WIDTH + 1;

  // Encodings shared with dram_scheduler_types.vh
  localparam logic [2:0] CMD_PRE = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;

  localparam logic [CW:0] D_RCD   = CW1'(T_RCD);
  localparam logic [CW:0] D_RP    = CW1'(T_RP);
  localparam logic [CW:0] D_RAS   = CW1'(T_RAS);
  localparam logic [CW:0] D_RTP   = CW1'(T_RTP);
  localparam logic [CW:0] D_RRD_S = CW1'(T_RRD_S);
  localparam logic [CW:0] D_RRD_L = CW1'(T_RRD_L);
  localparam logic [CW:0] D_CCD_S = CW1'(T_CCD_S);
  localparam logic [CW:0] D_CCD_L = CW1'(T_CCD_L);
  localparam logic [CW:0] D_FAW   = CW1'(T_FAW);

  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_EMIT, S_FLUSH_SCAN, S_FLUSH_DONE
  } state_e;

  typedef enum logic [1:0] {M_REQ, M_CLOSE, M_FLUSH} mode_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and all payload fields stable until that edge.

  state_e state_q, state_d;
  mode_e  mode_q;

  logic [BG_WIDTH-1:0]     rq_bg_q;
  logic [BANK_WIDTH-1:0]   rq_bank_q;
  logic [ROW_WIDTH-1:0]    rq_row_q;
  logic [COL_WIDTH-1:0]    rq_col_q;
  logic [REQ_ID_WIDTH-1:0] rq_id_q;
  logic                    rq_last_q;
  logic [NB_W-1:0]         scan_q;
  logic [CW-1:0]           gptr_q;

  logic [NB-1:0]           open_q;
  logic [ROW_WIDTH-1:0]    row_q [NB];
  logic [CW-1:0]           act_t_q [NB];
  logic [CW-1:0]           pre_t_q [NB];
  logic [CW-1:0]           rd_t_q  [NB];
  logic [NB-1:0]           act_v_q, pre_v_q, rd_v_q;
  logic [CW-1:0]           bg_act_t_q [NBG];
  logic [CW-1:0]           bg_rd_t_q  [NBG];
  logic [NBG-1:0]          bg_act_v_q, bg_rd_v_q;
  logic [CW-1:0]           any_act_t_q, any_rd_t_q;
  logic                    any_act_v_q, any_rd_v_q;
  logic [CW-1:0]           faw_q [4];
  logic [2:0]              faw_cnt_q;

  logic                    cmd_valid_q;
  logic [CW-1:0]           cmd_cycle_q;
  logic [2:0]              cmd_type_q;
  logic [BG_WIDTH-1:0]     cmd_bg_q;
  logic [BANK_WIDTH-1:0]   cmd_bank_q;
  logic [ROW_WIDTH-1:0]    cmd_row_q;
  logic [COL_WIDTH-1:0]    cmd_col_q;
  logic [REQ_ID_WIDTH-1:0] cmd_req_id_q;
  logic                    overflow_q;

  logic                    req_accept, cmd_fire, load_cmd, close_after_rd;
  logic [NB_W-1:0]         tgt, fire_idx;
  logic [BG_WIDTH-1:0]     tgt_bg;
  logic [2:0]              sel_type;
  logic [CW:0]             t_wide, gptr_wide;
  logic [CW-1:0]           t_sat, gptr_sat;
  logic                    t_ovf, gptr_ovf;

  assign req_ready      = (state_q == S_IDLE) && !flush && !rst;
  assign req_accept     = req_valid && req_ready;
  assign cmd_fire       = cmd_valid_q && cmd_ready;
  assign close_after_rd = (AUTO_CLOSE != 0) && rq_last_q;
  assign fire_idx       = {cmd_bg_q, cmd_bank_q};

  assign cmd_valid   = cmd_valid_q;
  assign cmd_cycle   = cmd_cycle_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_bg      = cmd_bg_q;
  assign cmd_bank    = cmd_bank_q;
  assign cmd_row     = cmd_row_q;
  assign cmd_col     = cmd_col_q;
  assign cmd_req_id  = cmd_req_id_q;
  assign busy        = (state_q != S_IDLE);
  assign flush_done  = (state_q == S_FLUSH_DONE);
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

  // Raise cur to base+dly when the history entry is valid and later.
  function automatic logic [CW:0] lim(input logic v, input logic [CW-1:0] base,
                                      input logic [CW:0] dly, input logic [CW:0] cur);
    logic [CW:0] cand;
    cand = {1'b0, base} + dly;
    return (v && (cand > cur)) ? cand : cur;
  endfunction

  always_comb begin
    tgt    = (state_q == S_FLUSH_SCAN) ? scan_q : {rq_bg_q, rq_bank_q};
    tgt_bg = tgt[NB_W-1:BANK_WIDTH];
    if ((state_q == S_FLUSH_SCAN) || (mode_q == M_CLOSE)) sel_type = CMD_PRE;
    else if (!open_q[tgt])                                 sel_type = CMD_ACT;
    else if (row_q[tgt] == rq_row_q)                       sel_type = CMD_RD;
    else                                                   sel_type = CMD_PRE;
  end

  always_comb begin
    t_wide = {1'b0, gptr_q};
    case (sel_type)
      CMD_PRE: begin
        t_wide = lim(act_v_q[tgt], act_t_q[tgt], D_RAS, t_wide);
        t_wide = lim(rd_v_q[tgt],  rd_t_q[tgt],  D_RTP, t_wide);
      end
      CMD_ACT: begin
        t_wide = lim(pre_v_q[tgt],        pre_t_q[tgt],        D_RP,    t_wide);
        t_wide = lim(bg_act_v_q[tgt_bg],  bg_act_t_q[tgt_bg],  D_RRD_L, t_wide);
        t_wide = lim(any_act_v_q,         any_act_t_q,         D_RRD_S, t_wide);
        t_wide = lim(faw_cnt_q == 3'd4,   faw_q[0],            D_FAW,   t_wide);
      end
      default: begin
        t_wide = lim(act_v_q[tgt],       act_t_q[tgt],       D_RCD,   t_wide);
        t_wide = lim(bg_rd_v_q[tgt_bg],  bg_rd_t_q[tgt_bg],  D_CCD_L, t_wide);
        t_wide = lim(any_rd_v_q,         any_rd_t_q,         D_CCD_S, t_wide);
      end
    endcase
    t_ovf     = t_wide[CW];
    t_sat     = t_ovf ? '1 : t_wide[CW-1:0];
    gptr_wide = {1'b0, cmd_cycle_q} + CW1'(1);
    gptr_ovf  = gptr_wide[CW];
    gptr_sat  = gptr_ovf ? '1 : gptr_wide[CW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush)          state_d = S_FLUSH_SCAN;
        else if (req_valid) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        load_cmd = 1'b1;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (cmd_fire) begin
          if (mode_q == M_FLUSH)       state_d = (scan_q == '1) ? S_FLUSH_DONE : S_FLUSH_SCAN;
          else if (cmd_type_q == CMD_RD) state_d = close_after_rd ? S_DECIDE : S_IDLE;
          else if (mode_q == M_CLOSE)  state_d = S_IDLE;
          else                         state_d = S_DECIDE;
        end
      end
      S_FLUSH_SCAN: begin
        if (open_q[scan_q]) begin
          load_cmd = 1'b1;
          state_d  = S_EMIT;
        end else if (scan_q == '1) begin
          state_d = S_FLUSH_DONE;
        end
      end
      S_FLUSH_DONE: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_REQ;
      rq_bg_q      <= '0;
      rq_bank_q    <= '0;
      rq_row_q     <= '0;
      rq_col_q     <= '0;
      rq_id_q      <= '0;
      rq_last_q    <= 1'b0;
      scan_q       <= '0;
      gptr_q       <= '0;
      open_q       <= '0;
      act_v_q      <= '0;
      pre_v_q      <= '0;
      rd_v_q       <= '0;
      bg_act_v_q   <= '0;
      bg_rd_v_q    <= '0;
      any_act_t_q  <= '0;
      any_rd_t_q   <= '0;
      any_act_v_q  <= 1'b0;
      any_rd_v_q   <= 1'b0;
      faw_cnt_q    <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_cycle_q  <= '0;
      cmd_type_q   <= '0;
      cmd_bg_q     <= '0;
      cmd_bank_q   <= '0;
      cmd_row_q    <= '0;
      cmd_col_q    <= '0;
      cmd_req_id_q <= '0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        row_q[i]   <= '0;
        act_t_q[i] <= '0;
        pre_t_q[i] <= '0;
        rd_t_q[i]  <= '0;
      end
      for (int i = 0; i < NBG; i++) begin
        bg_act_t_q[i] <= '0;
        bg_rd_t_q[i]  <= '0;
      end
      for (int i = 0; i < 4; i++) faw_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (req_accept) begin
        mode_q    <= M_REQ;
        rq_bg_q   <= req_bg;
        rq_bank_q <= req_bank;
        rq_row_q  <= req_row;
        rq_col_q  <= req_col;
        rq_id_q   <= req_id;
        rq_last_q <= req_last;
      end
      if ((state_q == S_IDLE) && flush) begin
        mode_q <= M_FLUSH;
        scan_q <= '0;
      end
      if ((state_q == S_FLUSH_SCAN) && !open_q[scan_q] && (scan_q != '1))
        scan_q <= scan_q + NB_W'(1);
      if (load_cmd) begin
        cmd_valid_q  <= 1'b1;
        cmd_cycle_q  <= t_sat;
        cmd_type_q   <= sel_type;
        cmd_bg_q     <= tgt[NB_W-1:BANK_WIDTH];
        cmd_bank_q   <= tgt[BANK_WIDTH-1:0];
        cmd_row_q    <= (sel_type == CMD_ACT) ? rq_row_q : '0;
        cmd_col_q    <= (sel_type == CMD_RD)  ? rq_col_q : '0;
        cmd_req_id_q <= (sel_type == CMD_RD)  ? rq_id_q  : '0;
        if (t_ovf) overflow_q <= 1'b1;
      end
      if (cmd_fire) begin
        cmd_valid_q <= 1'b0;
        gptr_q      <= gptr_sat;
        if (gptr_ovf) overflow_q <= 1'b1;
        case (cmd_type_q)
          CMD_PRE: begin
            pre_t_q[fire_idx] <= cmd_cycle_q;
            pre_v_q[fire_idx] <= 1'b1;
            open_q[fire_idx]  <= 1'b0;
          end
          CMD_ACT: begin
            act_t_q[fire_idx]    <= cmd_cycle_q;
            act_v_q[fire_idx]    <= 1'b1;
            open_q[fire_idx]     <= 1'b1;
            row_q[fire_idx]      <= cmd_row_q;
            bg_act_t_q[cmd_bg_q] <= cmd_cycle_q;
            bg_act_v_q[cmd_bg_q] <= 1'b1;
            any_act_t_q          <= cmd_cycle_q;
            any_act_v_q          <= 1'b1;
            // Entry 0 is the oldest once four ACTs have been recorded.
            faw_q[0] <= faw_q[1];
            faw_q[1] <= faw_q[2];
            faw_q[2] <= faw_q[3];
            faw_q[3] <= cmd_cycle_q;
            if (faw_cnt_q != 3'd4) faw_cnt_q <= faw_cnt_q + 3'd1;
          end
          default: begin
            rd_t_q[fire_idx]    <= cmd_cycle_q;
            rd_v_q[fire_idx]    <= 1'b1;
            bg_rd_t_q[cmd_bg_q] <= cmd_cycle_q;
            bg_rd_v_q[cmd_bg_q] <= 1'b1;
            any_rd_t_q          <= cmd_cycle_q;
            any_rd_v_q          <= 1'b1;
            if (close_after_rd) mode_q <= M_CLOSE;
          end
        endcase
        if ((mode_q == M_FLUSH) && (scan_q != '1)) scan_q <= scan_q + NB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_timeline_gen.sv
// Directed bench for dram_cmd_timeline_gen: three instances (defaults, fast timings,
// auto-close) driven from one sequence; a monitor checks emitted commands against queues.
module tb_dram_cmd_timeline_gen;
  localparam int BGW = 2, BKW = 2, RW = 16, CLW = 10, IDW = 8, CW = 16;
  localparam int NB  = 16;
  localparam int EW  = 3 + BGW + BKW + RW + CLW + IDW + CW;
  localparam logic [2:0] PRE = 3'd1, ACT = 3'd2, RD = 3'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req_valid = '0, flush = '0;
  logic [2:0] req_ready, cmd_valid, flush_done, busy, overflow;
  logic cmd_ready = 1'b1;
  logic [BGW-1:0] req_bg = '0;
  logic [BKW-1:0] req_bank = '0;
  logic [RW-1:0]  req_row = '0;
  logic [CLW-1:0] req_col = '0;
  logic [IDW-1:0] req_id = '0;
  logic           req_last = 1'b0;
  logic [CW-1:0]  cmd_cycle [3];
  logic [2:0]     cmd_type [3];
  logic [BGW-1:0] cmd_bg [3];
  logic [BKW-1:0] cmd_bank [3];
  logic [RW-1:0]  cmd_row [3];
  logic [CLW-1:0] cmd_col [3];
  logic [IDW-1:0] cmd_req_id [3];
  logic [2:0]     dbg_state [3];

  logic [EW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  dram_cmd_timeline_gen u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_id(req_id), .req_last(req_last), .flush(flush[0]), .flush_done(flush_done[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready), .cmd_cycle(cmd_cycle[0]),
    .cmd_type(cmd_type[0]), .cmd_bg(cmd_bg[0]), .cmd_bank(cmd_bank[0]),
    .cmd_row(cmd_row[0]), .cmd_col(cmd_col[0]), .cmd_req_id(cmd_req_id[0]),
    .busy(busy[0]), .overflow(overflow[0]), .dbg_state_o(dbg_state[0]));

  dram_cmd_timeline_gen #(.T_RCD(1), .T_CCD_S(1), .T_RRD_S(1), .T_FAW(20)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_id(req_id), .req_last(req_last), .flush(flush[1]), .flush_done(flush_done[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready), .cmd_cycle(cmd_cycle[1]),
    .cmd_type(cmd_type[1]), .cmd_bg(cmd_bg[1]), .cmd_bank(cmd_bank[1]),
    .cmd_row(cmd_row[1]), .cmd_col(cmd_col[1]), .cmd_req_id(cmd_req_id[1]),
    .busy(busy[1]), .overflow(overflow[1]), .dbg_state_o(dbg_state[1]));

  dram_cmd_timeline_gen #(.AUTO_CLOSE(1)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_id(req_id), .req_last(req_last), .flush(flush[2]), .flush_done(flush_done[2]),
    .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready), .cmd_cycle(cmd_cycle[2]),
    .cmd_type(cmd_type[2]), .cmd_bg(cmd_bg[2]), .cmd_bank(cmd_bank[2]),
    .cmd_row(cmd_row[2]), .cmd_col(cmd_col[2]), .cmd_req_id(cmd_req_id[2]),
    .busy(busy[2]), .overflow(overflow[2]), .dbg_state_o(dbg_state[2]));

  function automatic logic [EW-1:0] mk(input logic [2:0] ty, input int bg, input int bank,
                                       input int row, input int col, input int id, input int cyc);
    return {ty, BGW'(bg), BKW'(bank), RW'(row), CLW'(col), IDW'(id), CW'(cyc)};
  endfunction

  function automatic logic [EW-1:0] pack(input int k);
    return {cmd_type[k], cmd_bg[k], cmd_bank[k], cmd_row[k], cmd_col[k], cmd_req_id[k], cmd_cycle[k]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: every accepted command is compared against the head of its instance's queue.
  task automatic mon_cmd(input int k, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (k)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      $display("FAIL u%0d_cmd: got unexpected command %0h, expected none", k, got);
    end else begin
      check($sformatf("u%0d_cmd", k), 64'(got), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (!rst && cmd_valid[k] && cmd_ready) mon_cmd(k, pack(k));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input int bg, input int bank, input int row, input int col,
                      input int id, input bit last, input bit chk_lat);
    int guard;
    req_bg = BGW'(bg); req_bank = BKW'(bank); req_row = RW'(row);
    req_col = CLW'(col); req_id = IDW'(id); req_last = last;
    req_valid[k] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!req_ready[k] && guard < 300) begin @(negedge clk); guard++; end
    if (!req_ready[k]) begin
      n_checks++;
      $display("FAIL u%0d_req_ready: got 0 for 300 cycles, expected 1", k);
      tick();
      req_valid[k] = 1'b0;
      return;
    end
    tick();
    req_valid[k] = 1'b0;
    if (chk_lat) begin
      @(negedge clk); check("lat_accept_plus1_valid", 64'(cmd_valid[k]), 64'd0);
      @(negedge clk); check("lat_accept_plus2_valid", 64'(cmd_valid[k]), 64'd1);
    end
  endtask

  task automatic wait_idle(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy[k] && guard < 300) begin @(negedge clk); guard++; end
    if (busy[k]) begin
      n_checks++;
      $display("FAIL u%0d_idle: busy got 1 for 300 cycles, expected 0", k);
    end
    tick();
  endtask

  // Flush sampled at the next edge; counts negedges until flush_done.
  task automatic do_flush(input int k, input int exp_cycles, input bit with_req);
    int n;
    flush[k] = 1'b1;
    if (with_req) begin
      req_valid[k] = 1'b1;
      @(negedge clk);
      check("flush_req_ready", 64'(req_ready[k]), 64'd0);
    end
    tick();
    flush[k] = 1'b0;
    req_valid[k] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (with_req && n == 1) begin
        check("flush_busy", 64'(busy[k]), 64'd1);
        check("flush_state_scan", 64'(dbg_state[k]), 64'd3);
      end
    end while (!flush_done[k] && n < 300);
    check($sformatf("u%0d_flush_latency", k), 64'(n), 64'(exp_cycles));
    @(negedge clk);
    check("flush_done_pulse", 64'(flush_done[k]), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  logic [EW-1:0] cap;
  int n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_rst_cmd_valid", k), 64'(cmd_valid[k]), 64'd0);
      check($sformatf("u%0d_rst_busy", k), 64'(busy[k]), 64'd0);
      check($sformatf("u%0d_rst_flush_done", k), 64'(flush_done[k]), 64'd0);
      check($sformatf("u%0d_rst_overflow", k), 64'(overflow[k]), 64'd0);
      check($sformatf("u%0d_rst_req_ready", k), 64'(req_ready[k]), 64'd1);
    end
    tick();

    // First request: ACT then RD after tRCD
    exp_q0.push_back(mk(ACT, 0, 0, 5, 0, 0, 0));
    exp_q0.push_back(mk(RD,  0, 0, 0, 3, 7, 14));
    send(0, 0, 0, 5, 3, 7, 1'b0, 1'b1);
    // Row hit paced by tCCD_L; then a new bank in the same group
    exp_q0.push_back(mk(RD,  0, 0, 0, 4, 8, 20));
    send(0, 0, 0, 5, 4, 8, 1'b0, 1'b0);
    exp_q0.push_back(mk(ACT, 0, 1, 5, 0, 0, 21));
    exp_q0.push_back(mk(RD,  0, 1, 0, 1, 9, 35));
    send(0, 0, 1, 5, 1, 9, 1'b0, 1'b0);
    wait_idle(0);

    // Flush with banks 0 and 1 open: PREs bounded by gptr and tRAS
    exp_q0.push_back(mk(PRE, 0, 0, 0, 0, 0, 36));
    exp_q0.push_back(mk(PRE, 0, 1, 0, 0, 0, 53));
    do_flush(0, NB + 3, 1'b0);

    // Row conflict: PRE at tRAS, ACT at tRP, RD at tRCD
    do_reset();
    exp_q0.push_back(mk(ACT, 0, 0, 5, 0, 0, 0));
    exp_q0.push_back(mk(RD,  0, 0, 0, 2, 1, 14));
    send(0, 0, 0, 5, 2, 1, 1'b0, 1'b0);
    exp_q0.push_back(mk(PRE, 0, 0, 0, 0, 0, 32));
    exp_q0.push_back(mk(ACT, 0, 0, 9, 0, 0, 46));
    exp_q0.push_back(mk(RD,  0, 0, 0, 6, 2, 60));
    send(0, 0, 0, 9, 6, 2, 1'b0, 1'b0);
    wait_idle(0);

    // Fast timings: four ACTs across groups, fifth held by tFAW
    for (int g = 0; g < 4; g++) begin
      exp_q1.push_back(mk(ACT, g, 0, 10 + g, 0, 0, 2 * g));
      exp_q1.push_back(mk(RD,  g, 0, 0, g, g, 2 * g + 1));
      send(1, g, 0, 10 + g, g, g, 1'b0, 1'b0);
    end
    exp_q1.push_back(mk(ACT, 0, 1, 20, 0, 0, 20));
    exp_q1.push_back(mk(RD,  0, 1, 0, 9, 44, 21));
    send(1, 0, 1, 20, 9, 44, 1'b0, 1'b0);
    wait_idle(1);

    // Auto-close after the last request to a row, then an empty flush
    exp_q2.push_back(mk(ACT, 1, 2, 3, 0, 0, 0));
    exp_q2.push_back(mk(RD,  1, 2, 0, 17, 5, 14));
    exp_q2.push_back(mk(PRE, 1, 2, 0, 0, 0, 32));
    send(2, 1, 2, 3, 17, 5, 1'b1, 1'b0);
    wait_idle(2);
    do_flush(2, NB + 1, 1'b0);

    // Back-pressure: command must hold while cmd_ready is low, then reset drops it
    cmd_ready = 1'b0;
    send(0, 2, 0, 1, 5, 3, 1'b0, 1'b0);
    n = 0;
    while (!cmd_valid[0] && n < 50) begin @(negedge clk); n++; end
    check("hold_appear", 64'(cmd_valid[0]), 64'd1);
    cap = pack(0);
    check("hold_fields", 64'(cap), 64'(mk(ACT, 2, 0, 1, 0, 0, 61)));
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 64'(cmd_valid[0]), 64'd1);
      check("hold_stable", 64'(pack(0)), 64'(cap));
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_hold_cmd_valid", 64'(cmd_valid[0]), 64'd0);
    check("rst_hold_busy", 64'(busy[0]), 64'd0);
    check("rst_hold_req_ready", 64'(req_ready[0]), 64'd0);
    tick();
    rst = 1'b0;
    cmd_ready = 1'b1;

    // Flush and request together: flush wins, no command emitted
    do_flush(0, NB + 1, 1'b1);
    check("post_flush_idle", 64'(busy[0]), 64'd0);

    repeat (4) tick();
    check("u0_queue_empty", 64'(exp_q0.size()), 64'd0);
    check("u1_queue_empty", 64'(exp_q1.size()), 64'd0);
    check("u2_queue_empty", 64'(exp_q2.size()), 64'd0);
    for (int k = 0; k < 3; k++)
      check($sformatf("u%0d_overflow_end", k), 64'(overflow[k]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_cmd_timeline_gen.md
Name: dram_cmd_timeline_gen

Overview:
- Parametrised per-request DRAM command timeline generator; the next generation of the phase-3 schedule generator.
- Takes a stream of read requests (bank group, bank, row, column, id) over a valid/ready handshake and tracks open rows for all banks internally.
- Emits time-stamped PRE/ACT/RD commands over a valid/ready handshake to the schedule memory writer.
- Enforces per-bank-group timing (tRRD_S/L, tCCD_S/L), tRAS, tFAW and optional auto-close. Supports a flush that precharges all open banks.

Parameters:
- BG_WIDTH, 2, bank-group index width
- BANK_WIDTH, 2, bank-in-group index width (NB = 2^(BG_WIDTH+BANK_WIDTH))
- ROW_WIDTH, 16, row address width
- COL_WIDTH, 10, column address width
- REQ_ID_WIDTH, 8, request id width
- CYCLE_WIDTH, 16, timestamp width
- T_RCD, 14, ACT to RD, same bank
- T_RP, 14, PRE to ACT, same bank
- T_RAS, 32, ACT to PRE, same bank
- T_RTP, 8, RD to PRE, same bank
- T_RRD_S, 4, ACT to ACT, different bank group
- T_RRD_L, 6, ACT to ACT, same bank group
- T_CCD_S, 4, RD to RD, different bank group
- T_CCD_L, 6, RD to RD, same bank group
- T_FAW, 24, window allowed to contain at most 4 ACTs
- AUTO_CLOSE, 0, when 1, a request with req_last=1 is followed by a PRE to its bank

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_bg  in  BG_WIDTH  bank group
- req_bank  in  BANK_WIDTH  bank
- req_row  in  ROW_WIDTH  row
- req_col  in  COL_WIDTH  column
- req_id  in  REQ_ID_WIDTH  request id
- req_last  in  1  last request to this row (used only when AUTO_CLOSE=1)
- flush  in  1  precharge all open banks (sampled in IDLE only)
- flush_done  out  1  one-cycle pulse when the flush completes
- cmd_valid  out  1  command presented
- cmd_ready  in  1  consumer accepts the command
- cmd_cycle  out  CYCLE_WIDTH  scheduled issue cycle
- cmd_type  out  3  `CMD_PRE / `CMD_ACT / `CMD_RD from dram_scheduler_types.vh
- cmd_bg, cmd_bank  out  BG_WIDTH, BANK_WIDTH  target bank
- cmd_row  out  ROW_WIDTH  row (ACT only; 0 otherwise)
- cmd_col  out  COL_WIDTH  column (RD only; 0 otherwise)
- cmd_req_id  out  REQ_ID_WIDTH  id (RD only; 0 otherwise)
- busy  out  1  state != IDLE
- overflow  out  1  sticky; a computed time saturated

Behaviour:
- One clock; synchronous active-high reset. Reset clears all outputs to 0, the state to IDLE, the global pointer gptr to 0, all bank open flags, and all history-valid flags.
- req_ready = (state==IDLE) && !flush && !rst, combinational.
- States: IDLE, DECIDE, EMIT, FLUSH_SCAN, FLUSH_DONE.
- IDLE transitions:
  - flush=1 -> FLUSH_SCAN. Flush has priority over a simultaneous req_valid.
  - Otherwise a request handshake latches the request fields -> DECIDE.
- DECIDE selects the next command:
  - Bank open on the same row -> RD.
  - Bank open on a different row -> PRE.
  - Bank closed -> ACT.
  - The time t is computed in this cycle; registered outputs are presented the next cycle in EMIT with cmd_valid=1.
- EMIT holds every cmd_* field stable until cmd_ready=1. On the handshake:
  - After PRE or ACT -> DECIDE.
  - After RD -> DECIDE for the auto-close PRE when AUTO_CLOSE && req_last, else IDLE.
  - After the auto-close PRE -> IDLE.
- First command latency: request accepted at cycle N gives cmd_valid at N+2.
- Time t is the max of gptr and the applicable constraints. A constraint applies only if its history-valid flag is set:
  - PRE: ACT_b+T_RAS, RD_b+T_RTP.
  - ACT: PRE_b+T_RP, lastACT_samebg+T_RRD_L, lastACT_any+T_RRD_S, FAWq[oldest]+T_FAW (only once 4 ACTs are recorded).
  - RD: ACT_b+T_RCD, lastRD_samebg+T_CCD_L, lastRD_any+T_CCD_S.
- On each handshake: gptr <= t+1; update the matching history registers and flags.
  - ACT also pushes t into a 4-deep FAW FIFO; the oldest entry is dropped.
  - Open-row table updates: ACT sets open and row; PRE clears open.
- Arithmetic is done in CYCLE_WIDTH+1 bits. A result above 2^CYCLE_WIDTH-1 saturates to all-ones and sets overflow; overflow is cleared only by rst.
- FLUSH_SCAN walks bank indices 0..NB-1, one index per cycle.
  - Each open bank emits a PRE through EMIT, then the scan resumes at the next index.
  - After the last index -> FLUSH_DONE: flush_done=1 for one cycle -> IDLE.
  - A flush with no open banks takes NB+1 cycles and emits no commands.
- rst asserted in any state (including EMIT with cmd_valid=1 or mid-flush) returns to the reset condition at the next edge. The pending command is dropped.

Test Plan:
- Defaults, reset; request BG0 B0 row 5 col 3 id 7 -> ACT cycle 0 row 5; RD cycle 14 col 3 id 7; first cmd_valid 2 cycles after accept.
- Second request BG0 B0 row 5 -> RD only at cycle 20 (tCCD_L from 14); then BG0 B1 row 5 -> ACT 21, RD 35.
- From reset: BG0 B0 row 5, then BG0 B0 row 9 -> ACT 0, RD 14, PRE 32 (tRAS), ACT 46 (tRP), RD 60.
- Override T_RCD=1, T_CCD_S=1, T_RRD_S=1, T_FAW=20; requests to B0 of BG0..BG3, then BG0 B1 -> ACTs at 0, 2, 4, 6; fifth ACT at 20 (FAW), RD at 21.
- AUTO_CLOSE=1, request BG1 B2 row 3 with req_last=1 -> ACT 0, RD 14, PRE 32. Then flush with no banks open -> no commands, flush_done after NB+1 cycles.
- Hold cmd_ready=0 for 5 cycles during EMIT -> fields stable and cmd_valid held. Assert rst mid-hold -> cmd_valid=0, busy=0 next cycle. flush together with req_valid -> req_ready=0, flush wins.
